id_ex_stage_reg: RTL and testbench



---
 rtl/id_ex_stage_reg_pkg.sv | 15 +
 rtl/id_ex_stage_reg_sat_counter.sv | 13 +
 rtl/id_ex_stage_reg.sv | 87 ++++++++
 tb/tb_id_ex_stage_reg.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_reg_pkg.sv
// id_ex_stage_reg_pkg: shared pipeline widths, control bundle and bubble value
package id_ex_stage_reg_pkg;
  localparam int XLEN = 32;
  localparam int ALUOP_W = 4;
  typedef struct packed {
    logic regWrite;
    logic memRead;
    logic memWrite;
    logic memToReg;
    logic aluSrc;
    logic branch;
    logic [ALUOP_W-1:0] aluOp;
  } ctrl_t;
  localparam ctrl_t BUBBLE_CTRL = '0;
endpackage

// File: rtl/id_ex_stage_reg_sat_counter.sv
// sat_counter: saturating up-counter with synchronous active-low clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);
  always_ff @(posedge i_clk)
    if (!i_rst_n) o_cnt <= '0;
    else if (i_en && o_cnt != '1) o_cnt <= o_cnt + 1'b1;
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with flush/hold/nop bubbles; ID_EX_BUBBLE_CNT_EN enables the bubble counter
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int XLEN = id_ex_stage_reg_pkg::XLEN,
  parameter int ALUOP_W = id_ex_stage_reg_pkg::ALUOP_W,
  parameter int CNT_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_hold,
  input  logic               i_flush,
  input  logic               i_nop,
  input  logic [XLEN-1:0]    i_pc,
  input  logic [XLEN-1:0]    i_rs1_data,
  input  logic [XLEN-1:0]    i_rs2_data,
  input  logic [XLEN-1:0]    i_imm,
  input  logic [4:0]         i_rs1_addr,
  input  logic [4:0]         i_rs2_addr,
  input  logic [4:0]         i_rd_addr,
  input  logic               i_regWrite,
  input  logic               i_memRead,
  input  logic               i_memWrite,
  input  logic               i_memToReg,
  input  logic               i_aluSrc,
  input  logic               i_branch,
  input  logic [ALUOP_W-1:0] i_aluOp,
  output logic [XLEN-1:0]    o_pc,
  output logic [XLEN-1:0]    o_rs1_data,
  output logic [XLEN-1:0]    o_rs2_data,
  output logic [XLEN-1:0]    o_imm,
  output logic [4:0]         o_rs1_addr,
  output logic [4:0]         o_rs2_addr,
  output logic [4:0]         o_rd_addr,
  output logic               o_regWrite,
  output logic               o_memRead,
  output logic               o_memWrite,
  output logic               o_memToReg,
  output logic               o_aluSrc,
  output logic               o_branch,
  output logic [ALUOP_W-1:0] o_aluOp,
  output logic               o_valid,
  output logic [CNT_W-1:0]   o_bubble_cnt
);
  ctrl_t ctrl_q;
  logic bubble;
  assign bubble = i_flush || (i_nop && !i_hold);
  always_ff @(posedge i_clk)
    if (!i_rst_n || bubble) begin
      o_pc <= '0;
      o_rs1_data <= '0;
      o_rs2_data <= '0;
      o_imm <= '0;
      o_rs1_addr <= '0;
      o_rs2_addr <= '0;
      o_rd_addr <= '0;
      ctrl_q <= BUBBLE_CTRL;
      o_valid <= 1'b0;
    end else if (!i_hold) begin
      o_pc <= i_pc;
      o_rs1_data <= i_rs1_data;
      o_rs2_data <= i_rs2_data;
      o_imm <= i_imm;
      o_rs1_addr <= i_rs1_addr;
      o_rs2_addr <= i_rs2_addr;
      o_rd_addr <= i_rd_addr;
      ctrl_q <= '{i_regWrite, i_memRead, i_memWrite, i_memToReg, i_aluSrc, i_branch, i_aluOp};
      o_valid <= 1'b1;
    end
  assign o_regWrite = ctrl_q.regWrite;
  assign o_memRead = ctrl_q.memRead;
  assign o_memWrite = ctrl_q.memWrite;
  assign o_memToReg = ctrl_q.memToReg;
  assign o_aluSrc = ctrl_q.aluSrc;
  assign o_branch = ctrl_q.branch;
  assign o_aluOp = ctrl_q.aluOp;
`ifdef ID_EX_BUBBLE_CNT_EN
  sat_counter #(.W(CNT_W)) u_cnt (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_en(bubble),
    .o_cnt(o_bubble_cnt)
  );
`else
  assign o_bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed self-checking bench for id_ex_stage_reg
module tb_id_ex_stage_reg;
  logic clk = 1'b0;
  logic rst_n, hold, flush, nop;
  logic [31:0] pc, rs1_data, rs2_data, imm;
  logic [4:0] rs1_addr, rs2_addr, rd_addr;
  logic reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch;
  logic [3:0] alu_op;
  logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_imm;
  logic [4:0] o_rs1_addr, o_rs2_addr, o_rd_addr;
  logic o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_branch, o_valid;
  logic [3:0] o_alu_op, o_bubble_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;
  always #5 clk = ~clk;
  id_ex_stage_reg #(.CNT_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_hold(hold), .i_flush(flush), .i_nop(nop),
    .i_pc(pc), .i_rs1_data(rs1_data), .i_rs2_data(rs2_data), .i_imm(imm),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr), .i_rd_addr(rd_addr),
    .i_regWrite(reg_write), .i_memRead(mem_read), .i_memWrite(mem_write),
    .i_memToReg(mem_to_reg), .i_aluSrc(alu_src), .i_branch(branch), .i_aluOp(alu_op),
    .o_pc(o_pc), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_imm(o_imm),
    .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr),
    .o_regWrite(o_reg_write), .o_memRead(o_mem_read), .o_memWrite(o_mem_write),
    .o_memToReg(o_mem_to_reg), .o_aluSrc(o_alu_src), .o_branch(o_branch), .o_aluOp(o_alu_op),
    .o_valid(o_valid), .o_bubble_cnt(o_bubble_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [31:0] p, input logic [4:0] rd, input logic rw, input logic mr);
    pc = p;
    rs1_data = p ^ 32'hA5A5_0000;
    rs2_data = p + 32'd3;
    imm = p >> 2;
    rs1_addr = rd + 5'd1;
    rs2_addr = rd + 5'd2;
    rd_addr = rd;
    reg_write = rw;
    mem_read = mr;
    mem_to_reg = mr;
    mem_write = 1'b0;
    alu_src = 1'b1;
    branch = 1'b0;
    alu_op = p[3:0] | 4'h1;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic bump();
`ifdef ID_EX_BUBBLE_CNT_EN
    exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
`endif
  endtask
  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 0);
    chk({tag, "_pc"}, o_pc, 0);
    chk({tag, "_rs1d"}, o_rs1_data, 0);
    chk({tag, "_imm"}, o_imm, 0);
    chk({tag, "_rd"}, 32'(o_rd_addr), 0);
    chk({tag, "_rs1a"}, 32'(o_rs1_addr), 0);
    chk({tag, "_ctrl"}, {25'd0, o_reg_write, o_mem_read, o_mem_to_reg, o_alu_src, o_alu_op}, 0);
    chk({tag, "_cnt"}, 32'(o_bubble_cnt), 32'(exp_cnt));
  endtask
  initial begin
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0; nop = 1'b0;
    drive(32'h100, 5'd5, 1'b1, 1'b0);
    step();
    chk_bubble("reset");
    rst_n = 1'b1;
    step();
    chk("load_pc", o_pc, 32'h100);
    chk("load_rd", 32'(o_rd_addr), 5);
    chk("load_rw", 32'(o_reg_write), 1);
    chk("load_valid", 32'(o_valid), 1);
    chk("load_rs1d", o_rs1_data, 32'hA5A5_0100);
    chk("load_rs2d", o_rs2_data, 32'h103);
    chk("load_imm", o_imm, 32'h40);
    chk("load_rs2a", 32'(o_rs2_addr), 7);
    chk("load_aluop", 32'(o_alu_op), 1);
    drive(32'h104, 5'd7, 1'b1, 1'b1);
    step();
    chk("lw_memread", 32'(o_mem_read), 1);
    chk("lw_rd", 32'(o_rd_addr), 7);
    drive(32'h108, 5'd9, 1'b1, 1'b0);
    nop = 1'b1;
    step();
    bump();
    chk_bubble("nop");
    nop = 1'b0;
    step();
    chk("after_nop_pc", o_pc, 32'h108);
    chk("after_nop_rd", 32'(o_rd_addr), 9);
    chk("after_nop_valid", 32'(o_valid), 1);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h500 + 32'(i * 4), 5'(20 + i), 1'b0, 1'b1);
      step();
      chk("hold_pc", o_pc, 32'h108);
      chk("hold_rd", 32'(o_rd_addr), 9);
      chk("hold_mr", 32'(o_mem_read), 0);
      chk("hold_valid", 32'(o_valid), 1);
    end
    nop = 1'b1;
    step();
    chk("holdnop_pc", o_pc, 32'h108);
    chk("holdnop_valid", 32'(o_valid), 1);
    chk("holdnop_cnt", 32'(o_bubble_cnt), 32'(exp_cnt));
    hold = 1'b0;
    flush = 1'b1;
    step();
    bump();
    chk_bubble("flushnop");
    flush = 1'b0; nop = 1'b0;
    drive(32'h200, 5'd3, 1'b1, 1'b0);
    step();
    chk("load2_pc", o_pc, 32'h200);
    flush = 1'b1; hold = 1'b1;
    step();
    bump();
    chk_bubble("flushhold");
    flush = 1'b0; hold = 1'b0;
    drive(32'h300, 5'd4, 1'b1, 1'b0);
    step();
    chk("load3_pc", o_pc, 32'h300);
    chk("load3_valid", 32'(o_valid), 1);
    rst_n = 1'b0;
    step();
    exp_cnt = 0;
    chk_bubble("midreset");
    rst_n = 1'b1;
    step();
    chk("postrst_pc", o_pc, 32'h300);
    chk("postrst_rd", 32'(o_rd_addr), 4);
    chk("postrst_valid", 32'(o_valid), 1);
    nop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      bump();
      if (i == 13 || i == 14 || i == 19) chk("sat_cnt", 32'(o_bubble_cnt), 32'(exp_cnt));
    end
    chk("sat_final", 32'(o_bubble_cnt), 32'(exp_cnt));
    chk("sat_valid", 32'(o_valid), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
